// File: rtl/key_event.sv
// Turns a debounced key level into single-cycle short-press, long-press and
// auto-repeat events, plus a registered "key held" flag.
module key_event #(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter int CNT_W        = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic keyin,
    output logic held,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        PRESS,
        REPEAT
    } state_e;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_q, held_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        unique case (state_q)
            ARM: begin
                // A key still down when reset lifts must be released before it can count.
                if (!keyin) state_d = IDLE;
            end
            IDLE: begin
                if (keyin) begin
                    state_d = PRESS;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS: begin
                if (keyin) begin
                    if (cnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        state_d = REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    short_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            REPEAT: begin
                if (keyin) begin
                    if (cnt_q == REPEAT_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ARM;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == PRESS) || (state_d == REPEAT);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ARM;
            cnt_q    <= '0;
            held_q   <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            held_q   <= held_d;
            short_q  <= short_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
        end
    end

    assign held         = held_q;
    assign short_pulse  = short_q;
    assign long_pulse   = long_q;
    assign repeat_pulse = repeat_q;

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: a small-parameter instance (8/4) for the
// press-length boundaries and a default instance (100/20) for a 1.5 s hold.
module tb_key_event;

    logic clock = 1'b0;
    logic reset, keyin;
    logic held, short_pulse, long_pulse, repeat_pulse;
    logic reset_b, keyin_b;
    logic held_b, short_b, long_b, repeat_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    key_event #(.LONG_TICKS(8), .REPEAT_TICKS(4), .CNT_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .keyin       (keyin),
        .held        (held),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse)
    );

    key_event dut_def (
        .clock       (clock),
        .reset       (reset_b),
        .keyin       (keyin_b),
        .held        (held_b),
        .short_pulse (short_b),
        .long_pulse  (long_b),
        .repeat_pulse(repeat_b)
    );

    // Expected vectors are {held, short_pulse, long_pulse, repeat_pulse}.
    task automatic step_a(input logic r, input logic k, input logic [3:0] exp, input string tag);
        logic [3:0] got;
        @(negedge clock);
        reset = r;
        keyin = k;
        @(posedge clock);
        #1;
        got = {held, short_pulse, long_pulse, repeat_pulse};
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: held/short/long/repeat observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step_b(input logic r, input logic k, input logic [3:0] exp, input string tag);
        logic [3:0] got;
        @(negedge clock);
        reset_b = r;
        keyin_b = k;
        @(posedge clock);
        #1;
        got = {held_b, short_b, long_b, repeat_b};
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: held/short/long/repeat observed %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        keyin   = 1'b1;
        reset_b = 1'b1;
        keyin_b = 1'b0;

        // Reset with key down, then key still down after reset: ignored.
        for (int i = 0; i < 20; i++) step_a(1'b1, 1'b1, 4'b0000, "reset_key_down");
        for (int i = 0; i < 5; i++)  step_a(1'b0, 1'b1, 4'b0000, "arm_ignores_key");
        step_a(1'b0, 1'b0, 4'b0000, "arm_to_idle");

        // 3-sample press: held for 3 cycles, short pulse after first low.
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 4'b1000, "press3_held");
        step_a(1'b0, 1'b0, 4'b0100, "press3_short");
        step_a(1'b0, 1'b0, 4'b0000, "press3_after");

        // LONG_TICKS-1 samples: still a short press.
        for (int i = 0; i < 7; i++) step_a(1'b0, 1'b1, 4'b1000, "press7_held");
        step_a(1'b0, 1'b0, 4'b0100, "press7_short");
        step_a(1'b0, 1'b0, 4'b0000, "press7_after");

        // Exactly LONG_TICKS samples: long pulse only, release silent.
        for (int i = 1; i <= 7; i++) step_a(1'b0, 1'b1, 4'b1000, "press8_held");
        step_a(1'b0, 1'b1, 4'b1010, "press8_long");
        step_a(1'b0, 1'b0, 4'b0000, "press8_release_silent");
        step_a(1'b0, 1'b0, 4'b0000, "press8_after");

        // 20 samples: long after 8, repeats after 12, 16, 20.
        for (int i = 1; i <= 20; i++)
            step_a(1'b0, 1'b1, {1'b1, 1'b0, (i == 8), (i == 12 || i == 16 || i == 20)}, "press20");
        step_a(1'b0, 1'b0, 4'b0000, "press20_release_silent");

        // 1 high, 1 low, 1 high: two short pulses two cycles apart.
        step_a(1'b0, 1'b1, 4'b1000, "b2b_first_held");
        step_a(1'b0, 1'b0, 4'b0100, "b2b_first_short");
        step_a(1'b0, 1'b1, 4'b1000, "b2b_second_held");
        step_a(1'b0, 1'b0, 4'b0100, "b2b_second_short");
        step_a(1'b0, 1'b0, 4'b0000, "b2b_after");

        // Reset at sample 6 aborts the press; key held after reset is ignored.
        for (int i = 0; i < 5; i++) step_a(1'b0, 1'b1, 4'b1000, "abort_held");
        step_a(1'b1, 1'b1, 4'b0000, "abort_reset");
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 4'b0000, "abort_key_ignored");
        step_a(1'b0, 1'b0, 4'b0000, "abort_rearm");
        step_a(1'b0, 1'b1, 4'b1000, "abort_new_press");
        step_a(1'b0, 1'b0, 4'b0100, "abort_new_short");
        step_a(1'b0, 1'b0, 4'b0000, "abort_after");

        // Default parameters: 150 samples (1.5 s at 10 ms) of "add".
        step_b(1'b1, 1'b0, 4'b0000, "def_reset");
        step_b(1'b0, 1'b0, 4'b0000, "def_arm_to_idle");
        for (int i = 1; i <= 150; i++)
            step_b(1'b0, 1'b1, {1'b1, 1'b0, (i == 100), (i == 120 || i == 140)}, "def_hold");
        step_b(1'b0, 1'b0, 4'b0000, "def_release_silent");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
